// File: rtl/prbs_checker.sv
// ---------------------------------------------------------------------------
// prbs_checker
//
// Pseudo-random word-sequence checker. Words follow the recurrence
//     next(x) = ((x ^ (x[MSB] ? POLY : 0)) << 1) | ~x[MSB]   (WIDTH bits)
//
// Operation:
//   HUNT  : every valid word is loaded as the reference. A word that equals
//           next(previous word) extends the run of matches. LOCK_CNT
//           consecutive matches move the checker to CHECK.
//   CHECK : the reference free-runs ("flywheel"): every valid word is compared
//           with next(ref) and ref advances to next(ref) whatever arrived.
//           So one corrupted word costs exactly one error. LOSS_CNT
//           consecutive mismatches drop back to HUNT and reseed from the
//           offending word.
//
// Parameters:
//   WIDTH    : sequence word width (4..32)
//   POLY     : feedback tap mask, WIDTH bits
//   LOCK_CNT : consecutive matches needed to lock (1..15)
//   LOSS_CNT : consecutive mismatches that drop lock (1..15)
//   CNT_W    : width of the saturating statistics counters
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   in_data is sampled this cycle
//   in_data    in   received sequence word [WIDTH-1:0]
//   clr_cnt    in   synchronous clear of err_count / word_count
//   locked     out  checker is synchronised (registered state == CHECK)
//   err_pulse  out  one-cycle flag per word mismatched while locked
//   err_count  out  mismatched words while locked, saturating [CNT_W-1:0]
//   word_count out  words checked while locked, saturating [CNT_W-1:0]
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module prbs_checker #(
    parameter int                 WIDTH    = 8,
    parameter logic [WIDTH-1:0]   POLY     = 8'hC3,
    parameter int                 LOCK_CNT = 4,
    parameter int                 LOSS_CNT = 4,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  word_count
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    // run / miss are compared against "count minus one" so that the word that
    // completes the count is the one that triggers the transition.
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_CNT - 1);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        HUNT  = 1'b0,
        CHECK = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_reg,      state_next;
    logic [WIDTH-1:0]   ref_reg,        ref_next;
    logic               ref_valid_reg,  ref_valid_next;
    logic [3:0]         run_reg,        run_next;
    logic [3:0]         miss_reg,       miss_next;
    logic               err_pulse_reg,  err_pulse_next;

    // Statistics counters: index 0 = word_count, index 1 = err_count.
    logic [CNT_W-1:0]   cnt_reg  [2];
    logic [CNT_W-1:0]   cnt_next [2];
    logic [1:0]         cnt_inc;

    // -----------------------------------------------------------------------
    // Sequence predictor: pred = next(ref_reg)
    // Bit 0 is the inverted MSB; every other bit is the bit below it, XORed
    // with the corresponding tap when the MSB is set.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0]   pred;
    logic               word_match;

    assign pred[0] = ~ref_reg[WIDTH-1];

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_pred
            assign pred[gi] = ref_reg[gi-1] ^ (ref_reg[WIDTH-1] & POLY[gi-1]);
        end
    endgenerate

    assign word_match = (in_data == pred);

    // -----------------------------------------------------------------------
    // Process 1: state register (asynchronous reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= HUNT;
            ref_reg       <= '0;
            ref_valid_reg <= 1'b0;
            run_reg       <= '0;
            miss_reg      <= '0;
            err_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ref_reg       <= ref_next;
            ref_valid_reg <= ref_valid_next;
            run_reg       <= run_next;
            miss_reg      <= miss_next;
            err_pulse_reg <= err_pulse_next;
        end
    end

    // -----------------------------------------------------------------------
    // Process 2: next-state logic (state, reference, run, miss)
    // clr_cnt deliberately does not appear here: it only touches statistics.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        ref_next       = ref_reg;
        ref_valid_next = ref_valid_reg;
        run_next       = run_reg;
        miss_next      = miss_reg;

        if (in_valid) begin
            unique case (state_reg)
                HUNT: begin
                    // Every valid word reseeds the reference while hunting.
                    ref_next       = in_data;
                    ref_valid_next = 1'b1;
                    miss_next      = '0;
                    if (ref_valid_reg && word_match) begin
                        if (run_reg == LOCK_LAST) begin
                            state_next = CHECK;
                            run_next   = '0;
                        end else begin
                            run_next = run_reg + 4'd1;
                        end
                    end else begin
                        // Mismatch, or first word after (re)entering HUNT.
                        run_next = '0;
                    end
                end

                CHECK: begin
                    // Flywheel: the reference advances independently of the
                    // received word so a single bad word does not poison the
                    // following comparisons.
                    ref_next = pred;
                    if (word_match) begin
                        miss_next = '0;
                    end else if (miss_reg == LOSS_LAST) begin
                        state_next     = HUNT;
                        ref_next       = in_data;
                        ref_valid_next = 1'b1;
                        run_next       = '0;
                        miss_next      = '0;
                    end else begin
                        miss_next = miss_reg + 4'd1;
                    end
                end

                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Process 3: output logic (error pulse and counter increments)
    // -----------------------------------------------------------------------
    always_comb begin
        err_pulse_next = 1'b0;
        cnt_inc        = 2'b00;

        if (in_valid && (state_reg == CHECK)) begin
            cnt_inc[0] = 1'b1;             // word checked
            if (!word_match) begin
                cnt_inc[1]     = 1'b1;     // word in error
                err_pulse_next = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Saturating statistics counters. A clear wins over a same-cycle
    // increment so software never sees a stale count after clearing.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_comb begin
                cnt_next[gi] = cnt_reg[gi];
                if (clr_cnt) begin
                    cnt_next[gi] = '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != CNT_MAX)) begin
                    cnt_next[gi] = cnt_reg[gi] + CNT_ONE;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else begin
                    cnt_reg[gi] <= cnt_next[gi];
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign locked     = (state_reg == CHECK);
    assign err_pulse  = err_pulse_reg;
    assign word_count = cnt_reg[0];
    assign err_count  = cnt_reg[1];

endmodule

// File: tb/tb_prbs_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs_checker
//
// Directed scenarios (lock-up, clean run, single error, loss/relock, valid
// gaps, clear-vs-error, asynchronous mid-run reset) followed by a randomized
// phase. Expected values come from a behavioural model of the checker rules
// that uses integer arithmetic for the sequence recurrence.
// ---------------------------------------------------------------------------
module tb_prbs_checker;

    localparam int WIDTH    = 8;
    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 4;
    localparam int CNT_W    = 16;
    localparam int POLY_I   = 'hC3;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              clr_cnt;
    logic              locked;
    logic              err_pulse;
    logic [CNT_W-1:0]  err_count;
    logic [CNT_W-1:0]  word_count;

    prbs_checker #(
        .WIDTH    (WIDTH),
        .POLY     (8'hC3),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .clr_cnt    (clr_cnt),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Behavioural model state
    int m_locked;
    int m_have;
    int m_ref;
    int m_run;
    int m_miss;
    int m_err;
    int m_words;
    int m_pulse;

    // Sequence recurrence in plain arithmetic: doubling is the left shift,
    // "x < 128" is the inverted top bit.
    function automatic int nxt(input int x);
        int t;
        t = (x >= 128) ? (x ^ POLY_I) : x;
        return ((t * 2) % 256) + ((x < 128) ? 1 : 0);
    endfunction

    function automatic int sat_inc(input int x);
        return (x >= CNT_SAT) ? CNT_SAT : x + 1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_have = 0; m_ref = 0; m_run = 0;
        m_miss = 0;   m_err = 0;  m_words = 0; m_pulse = 0;
    endtask

    task automatic model_update(input bit v, input int d, input bit c);
        int e;
        m_pulse = 0;
        if (v) begin
            if (m_locked == 0) begin
                if (m_have != 0 && d == nxt(m_ref)) begin
                    m_run++;
                    if (m_run == LOCK_CNT) begin
                        m_locked = 1;
                        m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
                m_ref  = d;
                m_have = 1;
            end else begin
                e = nxt(m_ref);
                m_ref = e;
                m_words = sat_inc(m_words);
                if (d != e) begin
                    m_err = sat_inc(m_err);
                    m_pulse = 1;
                    m_miss++;
                    if (m_miss == LOSS_CNT) begin
                        m_locked = 0;
                        m_ref = d;
                        m_run = 0;
                        m_miss = 0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
        if (c) begin
            m_err = 0;
            m_words = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".locked"},     32'(locked),     32'(m_locked));
        check({tag, ".err_pulse"},  32'(err_pulse),  32'(m_pulse));
        check({tag, ".err_count"},  32'(err_count),  32'(m_err));
        check({tag, ".word_count"}, 32'(word_count), 32'(m_words));
    endtask

    // Drive one cycle of inputs, let the clock edge take them, then compare
    // every output against the model 1 ns after the edge.
    task automatic step(input bit v, input int d, input bit c, input string tag);
        in_valid = v;
        in_data  = 8'(d);
        clr_cnt  = c;
        @(posedge clk);
        #1;
        model_update(v, d, c);
        check_all(tag);
        $display("step %-14s v=%0d d=%02h clr=%0d | locked=%0d pulse=%0d err=%0d words=%0d",
                 tag, v, d, c, locked, err_pulse, err_count, word_count);
    endtask

    int seq;
    int d;
    int burst;
    bit v;
    bit c;
    logic [31:0] snap_err;
    logic [31:0] snap_words;
    logic [31:0] snap_locked;

    initial begin
        int lock_words [5];
        int clean_words [5];
        lock_words  = '{'h00, 'h01, 'h03, 'h07, 'h0F};
        clean_words = '{'h1F, 'h3F, 'h7F, 'hFF, 'h78};
        n_cmp = 0;
        n_bad = 0;
        burst = 0;

        // ---------------- reset ----------------
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_hold");
        rst = 1'b0;

        // ---------------- lock-up ----------------
        for (int i = 0; i < 5; i++) begin
            step(1'b1, lock_words[i], 1'b0, "lockup");
            if (i == 3) check("lock_not_yet", 32'(locked), 32'd0);
        end
        check("lock_up", 32'(locked), 32'd1);
        check("lock_err0", 32'(err_count), 32'd0);

        // ---------------- clean sequence ----------------
        for (int i = 0; i < 5; i++) step(1'b1, clean_words[i], 1'b0, "clean");
        check("clean_words", 32'(word_count), 32'd5);
        check("clean_errs",  32'(err_count),  32'd0);

        step(1'b0, 0, 1'b1, "clear");

        // ---------------- single corrupted word ----------------
        seq = m_ref;
        for (int i = 0; i < 4; i++) begin
            seq = nxt(seq);
            step(1'b1, (i == 1) ? (seq ^ 'h01) : seq, 1'b0, "single_err");
            if (i == 1) check("single_pulse", 32'(err_pulse), 32'd1);
        end
        check("single_err_count", 32'(err_count),  32'd1);
        check("single_words",     32'(word_count), 32'd4);
        check("single_locked",    32'(locked),     32'd1);

        step(1'b0, 0, 1'b1, "clear");

        // ---------------- loss of lock, then relock ----------------
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 'hAA, 1'b0, "loss");
            if (i == 2) check("loss_still_locked", 32'(locked), 32'd1);
        end
        check("loss_unlocked", 32'(locked),    32'd0);
        check("loss_errs",     32'(err_count), 32'd4);

        seq = 'h55;
        step(1'b1, seq, 1'b0, "relock");
        for (int i = 0; i < 4; i++) begin
            seq = nxt(seq);
            step(1'b1, seq, 1'b0, "relock");
        end
        check("relocked", 32'(locked), 32'd1);

        // ---------------- valid gaps ----------------
        snap_err = 32'(err_count); snap_words = 32'(word_count); snap_locked = 32'(locked);
        for (int i = 0; i < 3; i++) step(1'b0, $urandom_range(0, 255), 1'b0, "gap");
        check("gap_err",    32'(err_count),  snap_err);
        check("gap_words",  32'(word_count), snap_words);
        check("gap_locked", 32'(locked),     snap_locked);
        step(1'b1, nxt(m_ref), 1'b0, "gap_word");
        step(1'b0, $urandom_range(0, 255), 1'b0, "gap");
        step(1'b1, nxt(m_ref), 1'b0, "gap_word");
        check("gap_flywheel_errs", 32'(err_count), snap_err);

        // ---------------- clear coinciding with a mismatch ----------------
        step(1'b1, nxt(m_ref) ^ 'h80, 1'b1, "clr_vs_err");
        check("clr_vs_err_count", 32'(err_count), 32'd0);
        check("clr_vs_err_pulse", 32'(err_pulse), 32'd1);
        step(1'b1, nxt(m_ref), 1'b0, "post_clr");

        // ---------------- asynchronous mid-run reset ----------------
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        check("async_reset_locked", 32'(locked), 32'd0);
        #1 rst = 1'b0;
        seq = 'h3C;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq, 1'b0, "reset_relock");
            if (i == 3) check("reset_relock_not_yet", 32'(locked), 32'd0);
            seq = nxt(seq);
        end
        check("reset_relock", 32'(locked), 32'd1);

        // ---------------- randomized phase ----------------
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 31) == 0);
            if (burst > 0) begin
                d = $urandom_range(0, 255);
                burst--;
            end else begin
                d = (m_have != 0) ? nxt(m_ref) : $urandom_range(0, 255);
                if ($urandom_range(0, 15) == 0) d = d ^ (1 << $urandom_range(0, 7));
                if ($urandom_range(0, 63) == 0) burst = 6;
            end
            step(v, d, c, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the sequence word width (4..32).
REQ-002 SHALL have parameter POLY, default 8'hC3, giving the feedback tap mask (WIDTH bits).
REQ-003 SHALL have parameter LOCK_CNT, default 4, giving the consecutive matches needed to lock (1..15).
REQ-004 SHALL have parameter LOSS_CNT, default 4, giving the consecutive mismatches that drop lock (1..15).
REQ-005 SHALL have parameter CNT_W, default 16, giving the width of the statistics counters.
REQ-006 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is sampled this cycle.
REQ-009 SHALL have port in_data, input, WIDTH bits: received sequence word.
REQ-010 SHALL have port clr_cnt, input, 1 bit: synchronous clear of err_count and word_count.
REQ-011 SHALL have port locked, output, 1 bit: checker is synchronised to the sequence.
REQ-012 SHALL have port err_pulse, output, 1 bit: one-cycle flag for each word mismatched while locked.
REQ-013 SHALL have port err_count, output, CNT_W bits: mismatched words while locked, saturating.
REQ-014 SHALL have port word_count, output, CNT_W bits: words checked while locked, saturating.

Function
REQ-015 SHALL define next(x) = (((x XOR (x[WIDTH-1] ? POLY : 0)) << 1) | NOT x[WIDTH-1]), truncated to WIDTH bits.
REQ-016 SHALL act only on cycles with in_valid=1, and SHALL hold all state when in_valid=0.
REQ-017 SHALL implement the states HUNT (reset state) and CHECK; locked=1 exactly when the registered state is CHECK.
REQ-018 SHALL, in HUNT, compare in_data with next(ref), where ref is the previous valid word; on the first valid word after entering HUNT, ref is not yet valid, so the word only loads ref.
REQ-019 SHALL, in HUNT, load ref with in_data on every valid word, increment run on a match, and clear run on a mismatch.
REQ-020 SHALL move HUNT->CHECK on the valid word that makes run equal LOCK_CNT; locked rises on the next clock edge.
REQ-021 SHALL, in CHECK, compare in_data with next(ref) and then load ref with next(ref) (flywheel), so that one corrupted word causes exactly one error.
REQ-022 SHALL, in CHECK, increment word_count on every valid word and err_count on every mismatch; both saturate at all-ones.
REQ-023 SHALL assert err_pulse for exactly one cycle, on the clock edge after the mismatching word.
REQ-024 SHALL count consecutive CHECK mismatches in miss; any match clears miss.
REQ-025 SHALL move CHECK->HUNT on the mismatch that makes miss equal LOSS_CNT; that word is counted as an error, ref is loaded with in_data, and run and miss are cleared.
REQ-026 SHALL give clr_cnt priority over increments: when clr_cnt and an increment occur in the same cycle, the counter becomes 0.
REQ-027 SHALL NOT alter state, ref, run or miss when clr_cnt is asserted.
REQ-028 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, while rst=1, force state=HUNT, ref invalid, run=0, miss=0, locked=0, err_pulse=0, err_count=0 and word_count=0, regardless of clk.
REQ-030 SHALL, on reset asserted mid-operation, discard lock and counts, and resynchronise from the first valid word after rst falls.

Verification (WIDTH=8, POLY=C3, LOCK_CNT=4, LOSS_CNT=4)
REQ-031 SHALL cover lock-up: valid words 00,01,03,07,0F -> locked=1 one cycle after 0F; err_count=0.
REQ-032 SHALL cover the clean sequence: continue with 1F,3F,7F,FF,78 -> word_count=5, err_count=0, err_pulse never asserted.
REQ-033 SHALL cover a single corrupted word: 1F,3E,7F,FF after lock -> one err_pulse, err_count=1, locked stays 1.
REQ-034 SHALL cover loss of lock: four words AA after lock -> err_count=4 and locked=0 after the fourth; then 55,next(55)x4 -> relock.
REQ-035 SHALL cover valid gaps and clear: idle cycles with in_valid=0 inserted between words -> no state change; clr_cnt coinciding with a mismatch -> err_count=0.
REQ-036 SHALL cover mid-run reset: rst pulsed while locked, held under 1 clock period -> all outputs 0 immediately; relock needs LOCK_CNT+1 valid words.
